// File: rtl/tx_cmd_nib.sv
// Command-nibble byte transmitter: serializes a NIBBLES-wide payload into
// {CMD, nibble} bytes on a valid/ready stream, with stall and abort handling.
module tx_cmd_nib #(
  parameter logic [3:0] CMD       = 4'h0,
  parameter int         NIBBLES   = 4,
  parameter bit         MSN_FIRST = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_data,
  input  logic                 i_abort,
  output logic [7:0]           o_byte,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_nxt;
  logic [CW-1:0] cnt;
  logic          hs;

  // The nibble on the output side of the shift register.
  function automatic logic [3:0] head(input logic [W-1:0] v);
    return MSN_FIRST ? v[W-1 -: 4] : v[3:0];
  endfunction

  assign hs     = o_valid & i_ready;
  assign sr_nxt = MSN_FIRST ? (sr << 4) : (sr >> 4);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      o_byte  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            sr      <= i_data;
            cnt     <= '0;
            o_byte  <= {CMD, head(i_data)};
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Abort wins over a same-edge handshake: that byte is not sent.
          if (i_abort) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else if (hs) begin
            if (cnt == LAST) begin
              state   <= ST_IDLE;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              sr     <= sr_nxt;
              cnt    <= cnt + CW'(1);
              o_byte <= {CMD, head(sr_nxt)};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_cmd_nib.md
# tx_cmd_nib

Command-nibble byte transmitter for the GateMate ILA host link. It takes a multi-nibble payload word and emits it as a sequence of bytes on a valid/ready byte stream, toward the UART/SPI transmit path. Each byte carries the fixed command pattern in its upper nibble and one payload nibble in its lower nibble, which is the format the receive-side command-nibble matchers decode. The block handles payload capture, serialization, the stall handshake, and abort.

## Interface
- `CMD`, default 4'b0000: command pattern placed in bits [7:4] of every emitted byte.
- `NIBBLES`, default 4: payload nibble count, legal range 1..16.
- `MSN_FIRST`, default 1: 1 sends the most-significant nibble first; 0 sends the least-significant nibble first.
- `i_clk`  in  1  sole clock; all logic on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  request to transmit `i_data`; honoured only in IDLE.
- `i_data`  in  4*NIBBLES  payload; sampled on the accepted `i_start` edge only.
- `i_abort`  in  1  synchronous abort of the transfer in progress.
- `o_byte`  out  8  current byte, {CMD, nibble}.
- `o_valid`  out  1  `o_byte` is valid.
- `i_ready`  in  1  sink accepts `o_byte` on an edge where `o_valid` and `i_ready` are both high.
- `o_busy`  out  1  a transfer is in progress (state SEND).
- `o_done`  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- States: IDLE and SEND.
- Internal storage: a 4*NIBBLES shift register and a nibble counter of width clog2(NIBBLES), minimum 1 bit.
- Reset (asynchronous): state IDLE; shift register, counter, `o_byte`, `o_valid`, `o_busy`, `o_done` all 0.
- IDLE, `i_start`=1 and `i_abort`=0:
  - load `i_data` into the shift register and clear the counter;
  - present the first nibble: `o_byte`={CMD, i_data[4*NIBBLES-1 -: 4]} if MSN_FIRST, else {CMD, i_data[3:0]};
  - `o_valid`=1, `o_busy`=1, go to SEND.
- SEND, handshake (`o_valid` & `i_ready`) with counter < NIBBLES-1:
  - shift the register by one nibble in the configured direction and increment the counter;
  - present the next byte on the next cycle with `o_valid` held high, so back-to-back bytes are allowed.
- SEND, handshake with counter = NIBBLES-1:
  - `o_valid`=0, `o_busy`=0, `o_done`=1 for one cycle, go to IDLE.
- SEND with no handshake: `o_byte` and `o_valid` hold their values. `o_byte` must not change while stalled.
- `i_abort`=1 in SEND:
  - next edge goes to IDLE; `o_valid`=0, `o_busy`=0, counter cleared;
  - `o_done` is not pulsed;
  - abort takes priority over a simultaneous handshake, so that byte counts as not sent.
- `i_abort`=1 in IDLE: no effect. It also blocks a simultaneous `i_start`.
- `i_start` while in SEND: ignored. `i_data` changes after capture have no effect.
- NIBBLES=1: a single byte is sent and `o_done` follows its handshake.
- `o_done` is an IDLE-cycle pulse. An `i_start` in that same cycle is accepted, giving a new transfer with no extra gap.
- Byte format: bits [7:4]=CMD always; bits [3:0]=payload nibble. No parity or framing is added here.

## Timing
- All outputs are registered. There is no combinational path from `i_ready`, `i_start` or `i_abort` to any output.
- Start latency: `i_start` sampled at edge T → first byte valid after T.
- With `i_ready` tied to 1: bytes at edges T+1..T+NIBBLES; `o_done` high between edges T+NIBBLES and T+NIBBLES+1.
- Sustained rate: NIBBLES bytes per NIBBLES+1 cycles.
- Each stall cycle (`i_ready`=0) delays every later event by exactly one cycle.
- Abort latency: 1 edge.
- Reset mid-transfer: outputs go to 0 immediately (asynchronously); no `o_done`; the transfer is lost.

## Test plan
- Basic MSN order: CMD=4'hA, NIBBLES=4, MSN_FIRST=1, `i_data`=16'h1234, `i_ready`=1 → bytes 8'hA1, 8'hA2, 8'hA3, 8'hA4 on 4 consecutive cycles; `o_done` 1 cycle after the last byte; `o_busy` high for exactly 4 cycles.
- LSN order with stalls: MSN_FIRST=0, `i_data`=16'hBEEF, `i_ready` toggling 0/1 → 8'hAF, 8'hAE, 8'hAE, 8'hAB in that order; `o_byte` stable during every stall; total 8 cycles to `o_done`.
- Abort mid-stream: abort coinciding with the handshake of the 2nd byte → `o_valid`=0 next cycle, no `o_done`; only 1 handshake counted; a new `i_start` with 16'h5678 sends 8'hA5 first.
- Start during busy and back-to-back: `i_start` with 16'h0000 while sending 16'h1234 → ignored, output unchanged. `i_start` asserted in the `o_done` cycle with 16'h9ABC → 8'hA9 appears the next cycle.
- Async reset while stalled at byte 3 → `o_valid`, `o_busy`, `o_done`, `o_byte` read 0 before the next clock edge; the next transfer starts cleanly from nibble 0.
- Edge configuration: NIBBLES=1, CMD=4'h0, `i_data`=4'hF → single byte 8'h0F followed by `o_done`.
